// File: rtl/uart_pkg.sv
// Shared UART definitions. The receiver, the transmitter and the rx buffer all use them.
package uart_pkg;
  localparam int UART_DATA_W = 8;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer signal bundle: receiver byte-done input, FWFT read port and status.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
);
  logic                   byteReady;
  logic [UART_DATA_W-1:0] dataIn;
  logic [UART_DATA_W-1:0] rdData;
  logic                   rdValid;
  logic                   rdReady;
  logic [PTR_W:0]         count;
  logic                   full;
  logic                   overflow;
  logic                   clearOverflow;

  modport slave (
    input  byteReady, dataIn, rdReady, clearOverflow,
    output rdData, rdValid, count, full, overflow
  );

  modport master (
    output byteReady, dataIn, rdReady, clearOverflow,
    input  rdData, rdValid, count, full, overflow
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic single-clock FIFO. The head is read combinationally, and a push is accepted
// while full when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] ram [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign count   = count_q;
  assign popData = ram[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared. A reset only rewinds the pointers and the count.
  always_ff @(posedge clk) begin
    if (do_push) ram[wr_ptr_q] <= pushData;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer. It turns the receiver's byte-done level into one push per byte
// and reports bytes dropped while full through a sticky flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  logic                   prev_ready_q, prev_ready_d;
  logic                   overflow_q, overflow_d;
  logic                   push_stb, pop_req, drop;
  logic                   fifo_full, fifo_empty;
  logic [PTR_W:0]         fifo_count;
  logic [UART_DATA_W-1:0] fifo_head;

  sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_stb),
    .pushData (bus.dataIn),
    .pop      (pop_req),
    .popData  (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // prev_ready resets high so that a byteReady level still high after reset does not push.
  always_comb begin
    prev_ready_d = bus.byteReady;
    push_stb     = bus.byteReady & ~prev_ready_q;
    pop_req      = bus.rdReady & ~fifo_empty;
    drop         = push_stb & fifo_full & ~pop_req;
    overflow_d   = overflow_q;
    if (bus.clearOverflow) overflow_d = 1'b0;
    if (drop)              overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ready_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      prev_ready_q <= prev_ready_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.rdData   = fifo_head;
  assign bus.rdValid  = ~fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.full     = fifo_full;
  assign bus.overflow = overflow_q;
endmodule
